// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor ramp controller: FSM state encoding
// and the PWM full-scale duty computation.
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RAMP    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_REVERSE = 3'd3,
    ST_ESTOP   = 3'd4
  } state_t;

  function automatic int unsigned calc_pwm_max(input int unsigned clk_freq,
                                               input int unsigned pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Ramp step timer: pulses tick every STEP_CYCLES clocks while enabled and
// restarts from zero whenever enable drops.
module tick_gen #(
  parameter int unsigned STEP_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// H-bridge duty ramp controller with direction reversal and emergency stop.
// Optional command watchdog is built when MOTOR_CTRL_WATCHDOG_EN is defined.
module motor_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100000000,
  parameter int unsigned PWM_FREQ    = 20000,
  parameter int unsigned WL          = $clog2(CLK_FREQ / PWM_FREQ + 1),
  parameter int unsigned STEP_CYCLES = 5000,
  parameter int unsigned STEP        = 1,
  parameter int unsigned WDOG_CYCLES = 50000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [WL-1:0] i_cmd_duty,
  input  logic          i_cmd_dir,
  input  logic          i_estop,
  output logic [WL-1:0] o_duty_cycle,
  output logic          o_dir,
  output logic          o_busy,
  output logic [2:0]    o_state
);

  localparam logic [WL-1:0] PWM_MAX = WL'(calc_pwm_max(CLK_FREQ, PWM_FREQ));
  localparam logic [WL-1:0] STEP_W  = WL'(STEP);

  state_t        state;
  logic [WL-1:0] duty;
  logic [WL-1:0] target;
  logic          dir;
  logic          tick;
  logic          accept;
  logic          wdog_fire;
  logic [WL-1:0] cmd_target;
  logic [WL-1:0] ramp_next;
  logic [WL-1:0] down_next;
  state_t        rest_state;

  // Handshake: a command transfers on a clock edge where i_cmd_valid && o_cmd_ready.
  assign o_cmd_ready  = !reset && !i_estop && (state == ST_IDLE || state == ST_HOLD);
  assign accept       = i_cmd_valid && o_cmd_ready;
  assign o_busy       = (state == ST_RAMP) || (state == ST_REVERSE);
  assign o_state      = state;
  assign o_duty_cycle = duty;
  assign o_dir        = dir;

  assign cmd_target = (i_cmd_duty > PWM_MAX) ? PWM_MAX : i_cmd_duty;
  assign rest_state = (target == '0) ? ST_IDLE : ST_HOLD;
  assign down_next  = (duty > STEP_W) ? duty - STEP_W : '0;

  // Differences are taken before stepping so the duty never wraps or overshoots.
  always_comb begin
    ramp_next = duty;
    if (duty < target) begin
      ramp_next = ((target - duty) > STEP_W) ? duty + STEP_W : target;
    end else if (duty > target) begin
      ramp_next = ((duty - target) > STEP_W) ? duty - STEP_W : target;
    end
  end

  // Ramp and reverse exits always coincide with a tick (counter wraps to 0)
  // or drop the enable, so every new busy phase starts a full step period.
  tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (o_busy),
    .tick   (tick)
  );

`ifdef MOTOR_CTRL_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_cnt;
  logic           wdog_run;

  assign wdog_run  = (state == ST_RAMP) || (state == ST_HOLD);
  assign wdog_fire = wdog_run && !accept && (wdog_cnt == WDW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || accept || !wdog_run || wdog_fire) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      duty   <= '0;
      dir    <= 1'b1;
      target <= '0;
    end else if (i_estop) begin
      state  <= ST_ESTOP;
      duty   <= '0;
      target <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            target <= cmd_target;
            if (i_cmd_dir == dir || duty == '0) begin
              dir   <= i_cmd_dir;
              state <= ST_RAMP;
            end else begin
              state <= ST_REVERSE;
            end
          end else if (wdog_fire) begin
            target <= '0;
            state  <= ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (wdog_fire) begin
            target <= '0;
          end else if (duty == target) begin
            state <= rest_state;
          end else if (tick) begin
            duty <= ramp_next;
            if (ramp_next == target) state <= rest_state;
          end
        end
        ST_REVERSE: begin
          if (tick) begin
            duty <= down_next;
            if (down_next == '0) begin
              dir   <= ~dir;
              state <= ST_RAMP;
            end
          end
        end
        ST_ESTOP: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
